// File: rtl/gps_sample_capture.sv
// gps_sample_capture
// Captures DEPTH words of 1-bit GPS IF samples (16 per word, MSB-first,
// earliest sample in bit 15) into a single block RAM. Once the buffer is
// full, the words are played back to the CPU one per read strobe.
// A start pulse in any state restarts the capture. The din value present on
// the cycle after start is sample 0, which keeps code phase aligned with the
// demodulator code generators.
module gps_sample_capture #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          din,
    input  logic          rd,
    output logic [15:0]   dout,
    output logic          full,
    output logic [AW:0]   wcount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic [15:0]     shreg_r;
    logic [3:0]      bitcnt_r;
    logic [AW-1:0]   wptr_r;
    logic [AW-1:0]   rptr_r;
    logic [AW:0]     wcount_r;
    logic            full_r;
    logic [15:0]     dout_r;

    logic [15:0]     mem_r [DEPTH];

    logic [15:0]     word_s;
    logic            wr_en_s;

    // Assemble the word being completed and decide whether it is written this cycle.
    always_comb begin
        word_s  = {shreg_r[14:0], din};
        wr_en_s = 1'b0;
        if ((state_r == FILL) && !start && (bitcnt_r == 4'd15)) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Block RAM write port; contents are deliberately never cleared.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wptr_r] <= word_s;
        end
    end

    // Capture/playback state machine with registered outputs and the RAM read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            shreg_r  <= 16'd0;
            bitcnt_r <= 4'd0;
            wptr_r   <= '0;
            rptr_r   <= '0;
            wcount_r <= '0;
            full_r   <= 1'b0;
            dout_r   <= 16'd0;
        end else if (start) begin
            // start wins over a coincident rd, which is simply dropped
            state_r  <= FILL;
            shreg_r  <= 16'd0;
            bitcnt_r <= 4'd0;
            wptr_r   <= '0;
            rptr_r   <= '0;
            wcount_r <= '0;
            full_r   <= 1'b0;
            dout_r   <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    dout_r <= 16'd0;
                end
                FILL: begin
                    shreg_r  <= word_s;
                    bitcnt_r <= bitcnt_r + 4'd1;
                    dout_r   <= 16'd0;
                    if (bitcnt_r == 4'd15) begin
                        wptr_r   <= wptr_r + AW'(1);
                        wcount_r <= wcount_r + (AW+1)'(1);
                        if (wptr_r == AW'(DEPTH - 1)) begin
                            full_r  <= 1'b1;
                            state_r <= DONE;
                        end
                    end
                end
                DONE: begin
                    // rptr wraps naturally because DEPTH is a power of two
                    if (rd) begin
                        rptr_r <= rptr_r + AW'(1);
                    end
                    dout_r <= mem_r[rptr_r];
                end
                default: begin
                    state_r <= IDLE;
                    dout_r  <= 16'd0;
                end
            endcase
        end
    end

    assign dout   = dout_r;
    assign full   = full_r;
    assign wcount = wcount_r;

endmodule

// File: tb/tb_gps_sample_capture.sv
// Directed bench for gps_sample_capture: a scoreboard queue collects the
// words the bench packs from the din stream and pops them at playback.
module tb_gps_sample_capture;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int NCYC  = 16 * DEPTH;

    logic          clk;
    logic          rst;
    logic          start;
    logic          din;
    logic          rd;
    logic [15:0]   dout;
    logic          full;
    logic [AW:0]   wcount;

    int            checks;
    int            failures;

    logic [15:0]   exp_q[$];
    logic [15:0]   m_sh;
    int            m_bits;

    gps_sample_capture #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .din    (din),
        .rd     (rd),
        .dout   (dout),
        .full   (full),
        .wcount (wcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_sh   = 16'd0;
        m_bits = 0;
    endtask

    // drives one sample into the DUT and packs it into the model
    task automatic fill_cycle(input logic b);
        din  = b;
        m_sh = {m_sh[14:0], b};
        m_bits++;
        if (m_bits == 16) begin
            exp_q.push_back(m_sh);
            m_bits = 0;
        end
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_clear();
    endtask

    // host samples dout while asserting rd, then honours the 3-cycle spacing
    task automatic read_word(input string tag, input logic [15:0] exp);
        check(tag, {16'd0, dout}, {16'd0, exp});
        rd = 1'b1;
        tick();
        rd = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        logic [15:0] kk;
        logic [15:0] e;
        logic [15:0] word0;
        logic        b;

        checks   = 0;
        failures = 0;
        rst   = 1'b1;
        start = 1'b0;
        din   = 1'b0;
        rd    = 1'b0;
        model_clear();
        tick();
        tick();
        check("reset_dout", {16'd0, dout}, 32'd0);
        check("reset_full", {31'd0, full}, 32'd0);
        check("reset_wcount", 32'(wcount), 32'd0);
        rst = 1'b0;
        tick();

        // rd while idle is ignored
        rd = 1'b1;
        tick();
        rd = 1'b0;
        tick();
        tick();
        check("idle_rd_dout", {16'd0, dout}, 32'd0);

        // ---- packing order: 1,0,0,0,... period 16 ----
        do_start();
        for (int s = 0; s < NCYC; s++) begin
            if (s == NCYC - 1) begin
                check("pack_full_early", {31'd0, full}, 32'd0);
            end
            fill_cycle((s % 16) == 0);
        end
        din = 1'b0;
        check("pack_full_rise", {31'd0, full}, 32'd1);
        check("pack_wcount", 32'(wcount), 32'(DEPTH));
        tick();
        tick();
        for (int k = 0; k < 8; k++) begin
            read_word("pack_word", 16'h8000);
        end

        // ---- pattern playback: word k = k ----
        do_start();
        for (int s = 0; s < NCYC; s++) begin
            kk = 16'(s / 16);
            fill_cycle(kk[15 - (s % 16)]);
        end
        din = 1'b0;
        check("pat_full", {31'd0, full}, 32'd1);
        tick();
        tick();
        for (int k = 0; k < DEPTH; k++) begin
            e = exp_q.pop_front();
            if (k == 0) word0 = e;
            check("pat_model", {16'd0, e}, 32'(k));
            read_word("pat_word", e);
        end
        read_word("pat_wrap", word0);

        // ---- restart mid-fill ----
        do_start();
        for (int s = 0; s < 5000; s++) begin
            fill_cycle(1'($urandom));
        end
        check("restart_wcount_mid", 32'(wcount), 32'd312);
        do_start();
        check("restart_wcount_zero", 32'(wcount), 32'd0);
        check("restart_full_zero", {31'd0, full}, 32'd0);
        for (int s = 0; s < NCYC; s++) begin
            if (s == NCYC - 1) begin
                check("restart_full_early", {31'd0, full}, 32'd0);
            end
            fill_cycle(1'($urandom));
        end
        din = 1'b0;
        check("restart_full_rise", {31'd0, full}, 32'd1);
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            read_word("restart_word", exp_q.pop_front());
        end

        // ---- collision: start and rd together in DONE, rd during FILL ----
        start = 1'b1;
        rd    = 1'b1;
        tick();
        start = 1'b0;
        rd    = 1'b0;
        model_clear();
        check("coll_full", {31'd0, full}, 32'd0);
        check("coll_wcount", 32'(wcount), 32'd0);
        check("coll_dout", {16'd0, dout}, 32'd0);
        for (int s = 0; s < NCYC; s++) begin
            b = 1'($urandom);
            if ((s % 2000) == 1000) begin
                rd = 1'b1;
                fill_cycle(b);
                rd = 1'b0;
                check("fill_rd_dout", {16'd0, dout}, 32'd0);
            end else begin
                fill_cycle(b);
            end
        end
        din = 1'b0;
        check("coll_full_rise", {31'd0, full}, 32'd1);
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            read_word("coll_word", exp_q.pop_front());
        end

        // ---- asynchronous reset mid-fill ----
        do_start();
        for (int s = 0; s < 100; s++) begin
            fill_cycle(1'($urandom));
        end
        check("pre_rst_wcount", 32'(wcount), 32'd6);
        #2;
        rst = 1'b1;
        #1;
        check("rst_dout", {16'd0, dout}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_wcount", 32'(wcount), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            read_word("post_rst_dout", 16'h0000);
        end
        check("post_rst_full", {31'd0, full}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gps_sample_capture.md
# gps_sample_capture

Captures a contiguous block of 1-bit GPS IF samples into on-chip block RAM, packed 16 samples per word, and plays them back to the embedded CPU one word per read strobe for acquisition FFT processing. Sits directly downstream of the registered `sample` bit in the GPS top level. Fed by the sampler-reset event (`wrEvt & op[GPS_SAMPLER_RST]`) and the sample-read event (`wrEvt & op[GET_GPS_SAMPLES]`). Its `dout` drives `gps_dout` whenever a sample read is in progress.

## Interface
- `DEPTH`, 1024: capture length in 16-bit words (16384 samples); must be a power of two.
- `AW`, 10: address width, log2(DEPTH).

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a new capture.
- `din`  in  1  registered sample bit, one new sample per `clk`.
- `rd`  in  1  one-cycle read strobe that pops the current word.
- `dout`  out  16  current playback word.
- `full`  out  1  high once the capture is complete.
- `wcount`  out  AW+1  number of words written in the current capture.

## Operation
- **States:**
  - IDLE: after `rst`.
  - FILL: capturing.
  - DONE: buffer full, playback active.
- **`start`, in any state:**
  - Clears `bitcnt` (4 bits), `wptr`, `rptr`, `wcount` and `full`.
  - Next state is FILL.
  - Memory contents are not cleared.
- **FILL, every cycle:**
  - `shreg <= {shreg[14:0], din}` (MSB-first; the earliest sample lands in bit 15).
  - `bitcnt` increments modulo 16.
  - When `bitcnt==15`, writes `{shreg[14:0], din}` to `mem[wptr]`, then increments `wptr` and `wcount`.
  - When the write at `wptr==DEPTH-1` completes: `full <= 1`, state goes to DONE, and `wcount==DEPTH`.
- **First sample:** the `din` value present on the cycle after `start` is sample 0. That is the same cycle on which the DEMOD code generators come out of reset, so code phase is referenced to sample 0.
- **DONE:**
  - Capture stops and `din` is ignored.
  - `rd` advances `rptr` (wraps from DEPTH-1 to 0).
  - `dout` is loaded registered from `mem[rptr]` and tracks `rptr`.
- **`rd` in IDLE or FILL:** ignored; `rptr` unchanged, `dout` stays 0.
- **`start` and `rd` in the same cycle:** `start` wins and `rd` is discarded.
- **Memory:** single BRAM, with synchronous write and synchronous read on the `rptr` port.

## Timing
- **Reset values:** `dout=0`, `full=0`, `wcount=0`, state IDLE, all pointers 0.
- **Capture duration:** 16·DEPTH cycles from `start` to `full` rising.
- **`full` timing:** rises on the edge that writes the last word.
- **`dout` after `full`:** shows `mem[0]` no later than 2 cycles after `full` rises.
- **Read latency:**
  - On `rd` at edge N, `rptr` advances at N.
  - `dout` shows the next word after edge N+1, i.e. a 2-cycle pop-to-valid latency.
  - The host samples `dout` in the same cycle it asserts `rd` (the word popped is the one displayed).
  - `rd` pulses must be at least 3 cycles apart; the CPU instruction rate guarantees this.
- **`wcount`:** increments on the same edge as each memory write.
- **`rst` mid-capture:** aborts immediately to IDLE. Partial memory contents are left unspecified; `full` stays 0.

## Test plan
- **Reset:** assert `rst` mid-FILL -> `dout=0`, `full=0`, `wcount=0` on the same cycle; later `rd` pulses leave `dout=0`.
- **Packing order:** `start`, then drive `din = 1,0,0,0,…` (period 16) -> every word reads `0x8000`; `full` rises exactly 16·DEPTH cycles after `start`.
- **Pattern playback:** drive `din` from a counter LSB pattern giving word k = k[15:0] -> DEPTH reads return 0x0000, 0x0001, … 0x03FF in order; read DEPTH+1 returns 0x0000 (wrap).
- **Restart mid-fill:** `start` at cycle 5000 of FILL -> `wcount` returns to 0; `full` rises 16·DEPTH cycles after the second `start`; word 0 reflects the post-restart data.
- **Collision and early read:** `start` and `rd` in the same cycle while in DONE -> `rptr` is 0 and state is FILL; `rd` during FILL -> `dout` stays 0 and the first read after `full` returns word 0.
